// File: rtl/serial_pattern_receiver.sv
// Serial test-pattern receiver: frames FRAME_LEN bits MSB-first after idle-high + start bit, checks against 4 patterns.
// Latency: frame_valid one clk after the edge sampling the last bit. No backpressure; rx_en=0 aborts to idle.
module serial_pattern_receiver #(
    parameter int FRAME_LEN = 100,
    parameter int IDLE_MIN  = 1,
    parameter logic [FRAME_LEN-1:0] PAT_A = 100'h5555555555555555555555555,
    parameter logic [FRAME_LEN-1:0] PAT_B = 100'h3333333333333333333333333,
    parameter logic [FRAME_LEN-1:0] PAT_C = 100'h0F0F0F0F0F0F0F0F0F0F0F0F0,
    parameter logic [FRAME_LEN-1:0] PAT_D = 100'h0000000000000FFFFFFFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_en,
    input  logic                 exp_polarity,
    input  logic                 exp_state,
    output logic                 busy,
    output logic                 frame_valid,
    output logic [FRAME_LEN-1:0] frame_data,
    output logic                 match_hit,
    output logic [1:0]           match_id,
    output logic [6:0]           err_count,
    output logic                 frame_ok
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int IW = $clog2(IDLE_MIN + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RECV  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic [1:0]           exp_sel_q, exp_sel_d;
    logic [3:0]           mis_q, mis_d;
    logic [6:0]           err_acc_q, err_acc_d;

    logic                 frame_valid_q, frame_valid_d;
    logic [FRAME_LEN-1:0] frame_data_q, frame_data_d;
    logic                 match_hit_q, match_hit_d;
    logic [1:0]           match_id_q, match_id_d;
    logic [6:0]           err_count_q, err_count_d;
    logic                 frame_ok_q, frame_ok_d;

    logic [CW-1:0] bit_idx;
    logic [3:0]    pat_bits;
    logic [3:0]    diff;
    logic [1:0]    exp_now;

    // bit_cnt is 0 in ARMED, so the same index serves the start bit and the body bits
    assign bit_idx  = CW'(FRAME_LEN - 1) - bit_cnt_q;
    assign pat_bits = {PAT_D[bit_idx], PAT_C[bit_idx], PAT_B[bit_idx], PAT_A[bit_idx]};
    assign diff     = {4{rx}} ^ pat_bits;
    assign exp_now  = {exp_polarity, exp_state};

    always_comb begin
        state_d       = state_q;
        idle_cnt_d    = idle_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        exp_sel_d     = exp_sel_q;
        mis_d         = mis_q;
        err_acc_d     = err_acc_q;
        frame_valid_d = 1'b0;
        frame_data_d  = frame_data_q;
        match_hit_d   = match_hit_q;
        match_id_d    = match_id_q;
        err_count_d   = err_count_q;
        frame_ok_d    = frame_ok_q;

        if (!rx_en) begin
            state_d    = S_IDLE;
            idle_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx) begin
                        if (idle_cnt_q == IW'(IDLE_MIN - 1)) begin
                            idle_cnt_d = IW'(IDLE_MIN);
                            state_d    = S_ARMED;
                        end else begin
                            idle_cnt_d = idle_cnt_q + 1'b1;
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
                S_ARMED: begin
                    if (!rx) begin
                        exp_sel_d  = exp_now;
                        shift_d    = {shift_q[FRAME_LEN-2:0], rx};
                        mis_d      = diff;
                        // pattern index is the bitwise inverse of {polarity,state}
                        err_acc_d  = 7'(diff[~exp_now]);
                        bit_cnt_d  = CW'(1);
                        idle_cnt_d = '0;
                        state_d    = S_RECV;
                    end
                end
                S_RECV: begin
                    shift_d   = {shift_q[FRAME_LEN-2:0], rx};
                    mis_d     = mis_q | diff;
                    err_acc_d = err_acc_q + 7'(diff[~exp_sel_q]);
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q + 1'b1 == CW'(FRAME_LEN)) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    frame_valid_d = 1'b1;
                    frame_data_d  = shift_q;
                    match_hit_d   = ~&mis_q;
                    match_id_d    = 2'd0;
                    for (int k = 3; k >= 0; k--) begin
                        if (!mis_q[k]) begin
                            match_id_d = 2'(k);
                        end
                    end
                    err_count_d = err_acc_q;
                    frame_ok_d  = (err_acc_q == 7'd0);
                    idle_cnt_d  = '0;
                    bit_cnt_d   = '0;
                    state_d     = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idle_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            exp_sel_q     <= 2'd0;
            mis_q         <= 4'd0;
            err_acc_q     <= 7'd0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            match_hit_q   <= 1'b0;
            match_id_q    <= 2'd0;
            err_count_q   <= 7'd0;
            frame_ok_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            exp_sel_q     <= exp_sel_d;
            mis_q         <= mis_d;
            err_acc_q     <= err_acc_d;
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            match_hit_q   <= match_hit_d;
            match_id_q    <= match_id_d;
            err_count_q   <= err_count_d;
            frame_ok_q    <= frame_ok_d;
        end
    end

    assign busy        = (state_q == S_RECV);
    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign match_hit   = match_hit_q;
    assign match_id    = match_id_q;
    assign err_count   = err_count_q;
    assign frame_ok    = frame_ok_q;

endmodule

// File: tb/tb_serial_pattern_receiver.sv
// Directed bench for serial_pattern_receiver: pattern frames, bit errors, reset/enable aborts, frame spacing.
module tb_serial_pattern_receiver;

    localparam logic [99:0] PAT_A = 100'h5555555555555555555555555;
    localparam logic [99:0] PAT_B = 100'h3333333333333333333333333;
    localparam logic [99:0] PAT_C = 100'h0F0F0F0F0F0F0F0F0F0F0F0F0;
    localparam logic [99:0] PAT_D = 100'h0000000000000FFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        rx_en;
    logic        exp_polarity;
    logic        exp_state;
    logic        busy;
    logic        frame_valid;
    logic [99:0] frame_data;
    logic        match_hit;
    logic [1:0]  match_id;
    logic [6:0]  err_count;
    logic        frame_ok;

    int errors = 0;
    int checks = 0;
    int fv_cnt = 0;

    serial_pattern_receiver #(
        .FRAME_LEN(100), .IDLE_MIN(1),
        .PAT_A(PAT_A), .PAT_B(PAT_B), .PAT_C(PAT_C), .PAT_D(PAT_D)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_en(rx_en),
        .exp_polarity(exp_polarity), .exp_state(exp_state),
        .busy(busy), .frame_valid(frame_valid), .frame_data(frame_data),
        .match_hit(match_hit), .match_id(match_id), .err_count(err_count),
        .frame_ok(frame_ok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_valid === 1'b1) fv_cnt++;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_bits(input logic [99:0] w, input int first, input int n,
                             input logic [1:0] e0, input int tog, input logic [1:0] e1);
        {exp_polarity, exp_state} = e0;
        for (int i = first; i < first + n; i++) begin
            if (i == tog) {exp_polarity, exp_state} = e1;
            rx = w[99-i];
            tick();
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_en = 1'b1; exp_polarity = 1'b0; exp_state = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
        checks++; if (frame_data !== 100'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", frame_data); end
        checks++; if ({match_hit, match_id, err_count, frame_ok} !== 11'h0)
            begin errors++; $display("FAIL reset_results got hit=%b id=%0d err=%0d ok=%b exp all 0", match_hit, match_id, err_count, frame_ok); end
        rst = 1'b0;
    endtask

    task automatic test_pat_a();
        int f0;
        idle(4);
        f0 = fv_cnt;
        send_bits(PAT_A, 0, 1, 2'b11, -1, 2'b11);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pata_busy_recv got=%b exp=1", busy); end
        send_bits(PAT_A, 1, 99, 2'b11, -1, 2'b11);
        checks++; if (frame_valid !== 1'b0 || fv_cnt != f0) begin errors++; $display("FAIL pata_early_fv got=%b cnt=%0d exp=0 cnt=%0d", frame_valid, fv_cnt, f0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pata_busy_done got=%b exp=0", busy); end
        tick();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL pata_fv got=%b exp=1", frame_valid); end
        checks++; if (frame_data !== PAT_A) begin errors++; $display("FAIL pata_data got=%h exp=%h", frame_data, PAT_A); end
        checks++; if ({match_hit, match_id, err_count, frame_ok} !== {1'b1, 2'd0, 7'd0, 1'b1})
            begin errors++; $display("FAIL pata_results got hit=%b id=%0d err=%0d ok=%b exp 1/0/0/1", match_hit, match_id, err_count, frame_ok); end
        tick();
        checks++; if (frame_valid !== 1'b0 || fv_cnt != f0 + 1) begin errors++; $display("FAIL pata_pulse_width got=%b cnt=%0d exp=0 cnt=%0d", frame_valid, fv_cnt, f0 + 1); end
        checks++; if (frame_data !== PAT_A) begin errors++; $display("FAIL pata_hold got=%h exp=%h", frame_data, PAT_A); end
    endtask

    task automatic test_wrong_expect();
        idle(2);
        send_bits(PAT_C, 0, 100, 2'b11, -1, 2'b11);
        tick();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL patc_fv got=%b exp=1", frame_valid); end
        checks++; if ({match_hit, match_id, err_count, frame_ok} !== {1'b1, 2'd2, 7'd50, 1'b0})
            begin errors++; $display("FAIL patc_results got hit=%b id=%0d err=%0d ok=%b exp 1/2/50/0", match_hit, match_id, err_count, frame_ok); end
    endtask

    task automatic test_bit_error();
        logic [99:0] w;
        logic [99:0] one;
        one = 100'h1;
        w = PAT_D ^ (one << 50);
        idle(2);
        send_bits(w, 0, 100, 2'b00, -1, 2'b00);
        tick();
        checks++; if (frame_data !== w) begin errors++; $display("FAIL biterr_data got=%h exp=%h", frame_data, w); end
        checks++; if ({match_hit, match_id, err_count, frame_ok} !== {1'b0, 2'd0, 7'd1, 1'b0})
            begin errors++; $display("FAIL biterr_results got hit=%b id=%0d err=%0d ok=%b exp 0/0/1/0", match_hit, match_id, err_count, frame_ok); end
    endtask

    task automatic test_reset_abort();
        int f0;
        idle(2);
        f0 = fv_cnt;
        send_bits(PAT_B, 0, 40, 2'b10, -1, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (frame_data !== 100'h0 || err_count !== 7'd0) begin errors++; $display("FAIL abort_cleared got data=%h err=%0d exp 0/0", frame_data, err_count); end
        idle(2);
        send_bits(PAT_B, 0, 100, 2'b10, -1, 2'b10);
        tick();
        checks++; if (fv_cnt != f0 + 1) begin errors++; $display("FAIL abort_fv_count got=%0d exp=%0d", fv_cnt - f0, 1); end
        checks++; if (frame_data !== PAT_B) begin errors++; $display("FAIL abort_patb_data got=%h exp=%h", frame_data, PAT_B); end
        checks++; if ({match_hit, match_id, err_count, frame_ok} !== {1'b1, 2'd1, 7'd0, 1'b1})
            begin errors++; $display("FAIL abort_patb_results got hit=%b id=%0d err=%0d ok=%b exp 1/1/0/1", match_hit, match_id, err_count, frame_ok); end
    endtask

    task automatic test_back_to_back();
        int f0;
        idle(2);
        f0 = fv_cnt;
        send_bits(PAT_A, 0, 100, 2'b11, -1, 2'b11);
        idle(2);
        checks++; if (fv_cnt != f0 + 1 || frame_data !== PAT_A) begin errors++; $display("FAIL b2b_first got cnt=%0d data=%h exp cnt=1 data=%h", fv_cnt - f0, frame_data, PAT_A); end
        send_bits(PAT_B, 0, 100, 2'b10, -1, 2'b10);
        tick();
        checks++; if (frame_valid !== 1'b1 || frame_data !== PAT_B || match_id !== 2'd1 || err_count !== 7'd0)
            begin errors++; $display("FAIL b2b_second got fv=%b data=%h id=%0d err=%0d exp 1/%h/1/0", frame_valid, frame_data, match_id, err_count, PAT_B); end
        idle(2);
        f0 = fv_cnt;
        send_bits(PAT_C, 0, 100, 2'b01, -1, 2'b01);
        send_bits(PAT_D, 0, 100, 2'b00, -1, 2'b00);
        idle(120);
        checks++; if (fv_cnt != f0 + 1) begin errors++; $display("FAIL b2b_start_in_done got=%0d frame_valid exp=1", fv_cnt - f0); end
        checks++; if (frame_data !== PAT_C || err_count !== 7'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL b2b_done_hold got data=%h err=%0d busy=%b exp %h/0/0", frame_data, err_count, busy, PAT_C); end
    endtask

    task automatic test_rx_en_and_latch();
        int f0;
        idle(2);
        f0 = fv_cnt;
        send_bits(PAT_A, 0, 70, 2'b11, -1, 2'b11);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rxen_busy_before got=%b exp=1", busy); end
        rx_en = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rxen_busy_after got=%b exp=0", busy); end
        idle(3);
        rx_en = 1'b1;
        idle(110);
        checks++; if (fv_cnt != f0) begin errors++; $display("FAIL rxen_no_fv got=%0d exp=0", fv_cnt - f0); end
        checks++; if (frame_data !== PAT_C || match_id !== 2'd2 || err_count !== 7'd0)
            begin errors++; $display("FAIL rxen_hold got data=%h id=%0d err=%0d exp %h/2/0", frame_data, match_id, err_count, PAT_C); end
        send_bits(PAT_B, 0, 100, 2'b10, 10, 2'b11);
        tick();
        checks++; if (frame_valid !== 1'b1 || frame_data !== PAT_B) begin errors++; $display("FAIL latch_frame got fv=%b data=%h exp 1/%h", frame_valid, frame_data, PAT_B); end
        checks++; if ({match_hit, match_id, err_count, frame_ok} !== {1'b1, 2'd1, 7'd0, 1'b1})
            begin errors++; $display("FAIL latch_results got hit=%b id=%0d err=%0d ok=%b exp 1/1/0/1", match_hit, match_id, err_count, frame_ok); end
    endtask

    initial begin
        test_reset();
        test_pat_a();
        test_wrong_expect();
        test_bit_error();
        test_reset_abort();
        test_back_to_back();
        test_rx_en_and_latch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_pattern_receiver.md
Name: serial_pattern_receiver

Overview:
- Receiving end of the team's 100-bit serial test-pattern link: samples one bit per clk on `rx`, which idles high.
- Detects frame start, deserialises FRAME_LEN bits MSB-first and checks the frame against the four standard patterns.
- Reports the captured word, which pattern matched exactly, and a bit-error count against the expected pattern.
- Sits on the bench/loopback side, opposite the pattern transmitter, for link and DAC-path checking.

Parameters:
- FRAME_LEN, 100: bits per frame.
- IDLE_MIN, 1: consecutive high samples required before a start bit is accepted.
- PAT_A, shared constant PAT_A: pattern for polarity=1, state=1; match_id 0.
- PAT_B, shared constant PAT_B: pattern for polarity=1, state=0; match_id 1.
- PAT_C, shared constant PAT_C: pattern for polarity=0, state=1; match_id 2.
- PAT_D, shared constant PAT_D: pattern for polarity=0, state=0; match_id 3.
- All pattern MSBs are 0, because a frame's first bit is its start bit.

Ports:
- clk  in  1  system clock; one rx bit sampled per rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx  in  1  serial line; idles high.
- rx_en  in  1  receiver enable; low aborts and holds the receiver idle.
- exp_polarity  in  1  expected polarity; latched at frame start.
- exp_state  in  1  expected state; latched at frame start.
- busy  out  1  high while a frame is being received (RECV state).
- frame_valid  out  1  one-cycle pulse when a complete frame's results are updated.
- frame_data  out  FRAME_LEN  last complete frame; bit FRAME_LEN-1 is the first bit received.
- match_hit  out  1  last frame exactly equals at least one pattern.
- match_id  out  2  lowest-index exactly matching pattern; 0 when match_hit=0.
- err_count  out  7  mismatching bits against the expected pattern (0..FRAME_LEN).
- frame_ok  out  1  err_count==0 for the last frame.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, idle counter=0, bit counter=0; all outputs 0, including frame_data. This applies mid-frame as well: the partial frame is discarded and no frame_valid is issued.

State machine:
- IDLE: rx=1 increments the idle counter, saturating at IDLE_MIN. Counter reaching IDLE_MIN moves to ARMED. rx=0 clears the counter and stays in IDLE.
- ARMED: rx=1 stays. rx=0 is the start bit, which is also frame bit FRAME_LEN-1. On that sample:
  - latch exp_sel = {exp_polarity, exp_state};
  - store the bit in the shift register;
  - initialise four per-pattern mismatch flags and the error accumulator from that first bit;
  - set bit count=1 and move to RECV.
- RECV: each cycle, shift rx in at the LSB (MSB-first overall) and increment the bit count. For each pattern, set its mismatch flag if rx differs from that pattern's bit at index FRAME_LEN-1-count. Increment the error accumulator if rx differs from the expected pattern's bit. The sample that brings the count to FRAME_LEN moves to DONE.
- DONE: single cycle with no sampling.
  - Register frame_data, match_hit, match_id, err_count and frame_ok; pulse frame_valid=1.
  - Clear the idle counter and go to IDLE.
  - Line bits arriving during DONE are not captured, so at least IDLE_MIN high samples are needed after DONE before the next start.

Timing:
- Latency: frame_valid is asserted on the clk edge after the edge that sampled the last bit.
- Minimum gap between frames: 1 + IDLE_MIN cycles after the last bit.
- busy=1 exactly while in RECV.

Expected-pattern mapping: 11→PAT_A, 10→PAT_B, 01→PAT_C, 00→PAT_D. exp_* changes after the start bit have no effect on the current frame.

Outputs and boundaries:
- Result outputs hold their values until the next frame_valid.
- match_id priority: A > B > C > D.
- rx_en=0 in any state: go to IDLE, clear the counters, no frame_valid, result outputs held. rx_en=0 and rst=1 together behave as reset.
- err_count width is 7 bits, enough for counts up to 100 without saturation. FRAME_LEN ≤ 127 is required.
- No framing error is flagged. Every FRAME_LEN bits after a start bit form a frame.

Test Plan:
- rst, then rx=1 for 4 cycles, then PAT_A bits MSB-first with exp=11 -> frame_valid pulses exactly 1 cycle, 100 cycles after the start bit sample; frame_data=PAT_A, match_hit=1, match_id=0, err_count=0, frame_ok=1.
- PAT_C sent with exp=11 -> match_hit=1, match_id=2, err_count=popcount(PAT_A^PAT_C), frame_ok=0.
- PAT_D with bit index 50 inverted, exp=00 -> match_hit=0, match_id=0, err_count=1, frame_ok=0.
- rst=1 for 1 cycle after 40 bits of a frame, then a full PAT_B frame -> no frame_valid for the aborted frame; PAT_B result correct; busy drops the cycle after reset.
- Back-to-back frames, IDLE_MIN=1, with exactly 2 high cycles after DONE -> both frames decoded. With the next start bit sampled in DONE -> no second frame_valid.
- rx_en=0 at bit 70, and exp_sel toggled at bit 10 of a later frame -> no output change for the aborted frame; the later frame's err_count uses exp_sel latched at its start.
